// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: slew-rate-limited duty sequencer feeding motor_hub duty_i.
// A target arrives over valid/ready and duty_o walks toward it by STEP once every
// TICK_DIV clocks. A command watchdog forces a ramp-down when commands stop, and
// estop/timeout drop duty to zero at once until a clean fault clear.
module motor_ramp_ctrl #(
  parameter int RESOLUTION  = 12,
  parameter int STEP        = 16,
  parameter int TICK_DIV    = 1000,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  cmd_valid_i,
  input  logic [RESOLUTION-1:0] cmd_duty_i,
  output logic                  cmd_ready_o,
  input  logic                  estop_i,
  input  logic                  timeout_i,
  input  logic                  clear_i,
  output logic [RESOLUTION-1:0] duty_o,
  output logic                  at_target_o,
  output logic                  busy_o,
  output logic                  fault_o,
  output logic                  wdog_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RAMP  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = $clog2(WDOG_CYCLES);
  localparam logic [PW-1:0]         PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [WW-1:0]         WD_LAST  = WW'(WDOG_CYCLES - 1);
  localparam logic [RESOLUTION:0]   STEP_X   = (RESOLUTION + 1)'(STEP);

  logic [1:0]            state_q, state_d;
  logic [RESOLUTION-1:0] duty_q, duty_d;
  logic [RESOLUTION-1:0] target_q, target_d;
  logic                  at_target_q, at_target_d;
  logic                  wdog_q, wdog_d;
  logic [PW-1:0]         pre_cnt_q;
  logic [WW-1:0]         wd_cnt_q, wd_cnt_d;
  logic                  tick;
  logic                  accept;
  logic                  fault_req;
  logic [RESOLUTION-1:0] stepped;

  // The state is fully determined by the duty/target relation outside FAULT.
  function automatic logic [1:0] classify(input logic [RESOLUTION-1:0] d,
                                          input logic [RESOLUTION-1:0] t);
    if (d != t)      return ST_RAMP;
    else if (d == '0) return ST_IDLE;
    else             return ST_HOLD;
  endfunction

  assign tick        = (pre_cnt_q == PRE_LAST);
  assign cmd_ready_o = (state_q != ST_FAULT);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign fault_req   = estop_i || timeout_i;

  assign duty_o      = duty_q;
  assign at_target_o = at_target_q;
  assign busy_o      = (state_q == ST_RAMP);
  assign fault_o     = (state_q == ST_FAULT);
  assign wdog_o      = wdog_q;

  // Free-running ramp prescaler; retargeting never disturbs its phase.
  always_ff @(posedge clk_i or negedge reset_n) begin
    // NOTE: every register here uses <= so all state updates see pre-edge values.
    if (!reset_n)            pre_cnt_q <= '0;
    else if (tick)           pre_cnt_q <= '0;
    else                     pre_cnt_q <= pre_cnt_q + PW'(1);
  end

  // One slew step of duty toward the current target, computed one bit wider so
  // neither the upward sum nor the downward difference can wrap.
  always_comb begin
    logic [RESOLUTION:0] duty_x, target_x, sum_x, diff_x;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    stepped  = duty_q;
    duty_x   = {1'b0, duty_q};
    target_x = {1'b0, target_q};
    sum_x    = duty_x + STEP_X;
    diff_x   = duty_x - target_x;
    if (duty_q < target_q) begin
      stepped = (sum_x > target_x) ? target_q : sum_x[RESOLUTION-1:0];
    end else if (duty_q > target_q) begin
      stepped = (diff_x <= STEP_X) ? target_q : RESOLUTION'(duty_x - STEP_X);
    end
  end

  // Next-state logic: fault first, then fault recovery, then ramp/command/watchdog.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    wdog_d   = wdog_q;
    wd_cnt_d = wd_cnt_q;
    if (fault_req) begin
      // Any pending command this cycle is dropped.
      state_d  = ST_FAULT;
      duty_d   = '0;
      target_d = '0;
      wd_cnt_d = '0;
    end else if (state_q == ST_FAULT) begin
      wd_cnt_d = '0;
      if (clear_i) state_d = ST_IDLE;
    end else begin
      // A tick steps toward the pre-edge target; a new target is honoured next tick.
      if (tick) duty_d = stepped;
      if (accept) begin
        target_d = cmd_duty_i;
        wdog_d   = 1'b0;
        wd_cnt_d = '0;
      end else if (state_q == ST_IDLE) begin
        wd_cnt_d = '0;
      end else if (wd_cnt_q == WD_LAST) begin
        target_d = '0;
        wdog_d   = 1'b1;
        wd_cnt_d = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + WW'(1);
      end
      state_d = classify(duty_d, target_d);
    end
    at_target_d = (duty_d == target_d);
  end

  // Control and datapath registers, all updated on the same edge.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      duty_q      <= '0;
      target_q    <= '0;
      at_target_q <= 1'b1;
      wdog_q      <= 1'b0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      at_target_q <= at_target_d;
      wdog_q      <= wdog_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl: a value-level model of the ramp,
// watchdog and fault rules is compared against the DUT on every falling edge,
// and directed scenarios pin the model with hand-computed values.
module tb_motor_ramp_ctrl;

  localparam int RES  = 12;
  localparam int STEP = 16;
  localparam int TDIV = 4;
  localparam int WDOG = 200;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_valid;
  logic [RES-1:0] cmd_duty;
  logic           cmd_ready;
  logic           estop, tmo, clr;
  logic [RES-1:0] duty;
  logic           at_target, busy, fault, wdog;

  int n_checks = 0;
  int n_errors = 0;
  int last_before = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    int duty;
    int target;
    int since;   // clocks since last accept (outside idle/fault)
    int n;       // clocks since reset release
    bit fault;
    bit wdog;
  } model_t;

  model_t m;

  motor_ramp_ctrl #(
    .RESOLUTION(RES), .STEP(STEP), .TICK_DIV(TDIV), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk_i(clk), .reset_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_duty_i(cmd_duty), .cmd_ready_o(cmd_ready),
    .estop_i(estop), .timeout_i(tmo), .clear_i(clr),
    .duty_o(duty), .at_target_o(at_target), .busy_o(busy),
    .fault_o(fault), .wdog_o(wdog)
  );

  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t r;
    r.duty = 0; r.target = 0; r.since = 0; r.n = 0; r.fault = 1'b0; r.wdog = 1'b0;
    return r;
  endfunction

  // One clock of the behavioural rules, written as plain integer arithmetic.
  function automatic model_t model_next(model_t c, bit valid, int cmd, bit es, bit to, bit cl);
    model_t r = c;
    bit tk = ((c.n % TDIV) == TDIV - 1);
    r.n = c.n + 1;
    if (es || to) begin
      r.fault = 1'b1; r.duty = 0; r.target = 0; r.since = 0;
    end else if (c.fault) begin
      if (cl) r.fault = 1'b0;
      r.since = 0;
    end else begin
      if (tk) begin
        if (c.duty < c.target)
          r.duty = (c.duty + STEP > c.target) ? c.target : c.duty + STEP;
        else if (c.duty > c.target)
          r.duty = (c.duty - c.target <= STEP) ? c.target : c.duty - STEP;
      end
      if (valid) begin
        r.target = cmd; r.wdog = 1'b0; r.since = 0;
      end else if (c.duty == 0 && c.target == 0) begin
        r.since = 0;
      end else if (c.since == WDOG - 1) begin
        r.target = 0; r.wdog = 1'b1; r.since = 0;
      end else begin
        r.since = c.since + 1;
      end
    end
    return r;
  endfunction

  // Model advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, cmd_valid, int'(cmd_duty), estop, tmo, clr);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("model duty",      int'(duty),      m.duty);
      check("model at_target", int'(at_target), int'(m.duty == m.target));
      check("model busy",      int'(busy),      int'(!m.fault && m.duty != m.target));
      check("model fault",     int'(fault),     int'(m.fault));
      check("model ready",     int'(cmd_ready), int'(!m.fault));
      check("model wdog",      int'(wdog),      int'(m.wdog));
    end
  end

  task automatic step_clk();
    int old = int'(duty);
    @(negedge clk);
    if (int'(duty) != old) last_before = old;
  endtask

  task automatic send(input int v);
    cmd_valid = 1'b1;
    cmd_duty  = RES'(v);
    step_clk();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_duty(input string name, input int v, input int budget);
    for (int i = 0; i < budget && int'(duty) != v; i++) step_clk();
    check(name, int'(duty), v);
  endtask

  // Checks each successive duty change against a hand-computed list.
  task automatic expect_seq(input string name, input int exp_q[$]);
    foreach (exp_q[k]) begin
      int old = int'(duty);
      for (int i = 0; i < 2 * TDIV && int'(duty) == old; i++) step_clk();
      check(name, int'(duty), exp_q[k]);
    end
  endtask

  // Long ramps: re-send the same target often enough to keep the watchdog quiet.
  task automatic ramp_to(input string name, input int v);
    for (int r = 0; r < 60 && int'(duty) != v; r++) begin
      send(v);
      for (int i = 0; i < 100 && int'(duty) != v; i++) step_clk();
    end
    check(name, int'(duty), v);
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_duty = '0;
    estop = 1'b0; tmo = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // 1: reset state
    check("rst duty", int'(duty), 0);
    check("rst ready", int'(cmd_ready), 1);
    check("rst at_target", int'(at_target), 1);
    check("rst busy", int'(busy), 0);
    check("rst fault", int'(fault), 0);
    check("rst wdog", int'(wdog), 0);
    repeat (2) step_clk();

    // 2: ramp up from idle
    send(100);
    check("accept busy", int'(busy), 1);
    expect_seq("up seq", '{16, 32, 48, 64, 80, 96, 100});
    step_clk();
    check("hold100 at_target", int'(at_target), 1);
    check("hold100 busy", int'(busy), 0);

    // 3: ramp down in hold
    send(40);
    expect_seq("down seq", '{84, 68, 52, 40});
    step_clk();
    check("hold40 busy", int'(busy), 0);

    // 4: top boundary, then long ramp down with no underflow
    ramp_to("reach 4090", 4090);
    step_clk();
    send(4095);
    expect_seq("no wrap", '{4095});
    step_clk();
    check("hold4095 at_target", int'(at_target), 1);
    ramp_to("reach 3", 3);
    check("last step from", last_before, 15);

    // 5a: estop mid-ramp
    send(0);
    wait_duty("back to 0", 0, 16);
    send(100);
    wait_duty("reach 64", 64, 40);
    estop = 1'b1;
    step_clk();
    check("estop duty", int'(duty), 0);
    check("estop fault", int'(fault), 1);
    check("estop ready", int'(cmd_ready), 0);
    clr = 1'b1;
    repeat (3) step_clk();
    check("clear ignored", int'(fault), 1);
    clr = 1'b0; estop = 1'b0;
    repeat (2) step_clk();
    check("no clear yet", int'(fault), 1);
    clr = 1'b1;
    step_clk();
    clr = 1'b0;
    check("cleared fault", int'(fault), 0);
    check("cleared ready", int'(cmd_ready), 1);

    // 5b: timeout mid-ramp, with a same-cycle command that must be dropped
    send(100);
    wait_duty("reach 64 again", 64, 40);
    tmo = 1'b1; cmd_valid = 1'b1; cmd_duty = RES'(500);
    step_clk();
    cmd_valid = 1'b0;
    check("tmo duty", int'(duty), 0);
    check("tmo fault", int'(fault), 1);
    check("tmo ready", int'(cmd_ready), 0);
    clr = 1'b1;
    repeat (3) step_clk();
    check("tmo clear ignored", int'(fault), 1);
    clr = 1'b0; tmo = 1'b0;
    step_clk();
    clr = 1'b1;
    step_clk();
    clr = 1'b0;
    check("tmo cleared", int'(fault), 0);
    repeat (2 * TDIV) step_clk();
    check("dropped cmd duty", int'(duty), 0);

    // 6: watchdog expiry counted from the accept edge
    send(100);
    n = 0;
    for (int i = 0; i < 2 * WDOG && !wdog; i++) begin
      step_clk();
      n++;
    end
    check("wdog latency", n, WDOG);
    check("wdog duty at expiry", int'(duty), 100);
    check("wdog busy", int'(busy), 1);
    wait_duty("wdog ramp to 0", 0, 40);
    step_clk();
    check("wdog idle busy", int'(busy), 0);
    check("wdog sticky", int'(wdog), 1);
    send(50);
    check("wdog cleared", int'(wdog), 0);

    // Asynchronous reset mid-ramp
    repeat (3) step_clk();
    #2 rst_n = 1'b0;
    #1;
    check("async rst duty", int'(duty), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst at_target", int'(at_target), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step_clk();
    check("post rst duty", int'(duty), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
